// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types plus the arbiter's state encoding and limits.
// The request/response structs belong to the common bus package used across VTop.
package cbus_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  localparam int CBUS_ARB_MAX_REQ = 8;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of requester-side and CBusToAXI-side signals around the arbiter.
// The master view belongs to the arbiter; the slave view to requesters and downstream.
interface cbus_arbiter_if
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] oresps;
  cbus_req_t                oreq;
  cbus_resp_t               oresp;

  modport master (input ireqs, input oresp, output oreq, output oresps);
  modport slave  (output ireqs, output oresp, input oreq, input oresps);
endinterface

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid scanning prio, prio+1, ...
// A prio outside 0..NUM_REQ-1 is folded back into range rather than trusted.
module cbus_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   prio,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int prio_s;
  int best_s;
  int dist_s;

  // Keep the valid requester closest (cyclically) after prio.
  always_comb begin
    found  = 1'b0;
    idx    = {IDX_W{1'b0}};
    prio_s = int'(prio) % NUM_REQ;
    best_s = NUM_REQ;
    dist_s = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      dist_s = (j - prio_s + NUM_REQ) % NUM_REQ;
      if (valid[j] && (dist_s < best_s)) begin
        best_s = dist_s;
        idx    = IDX_W'(j);
        found  = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing the CBus port in front of CBusToAXI; a grant is
// held for a whole burst and released one cycle after the ready&&last beat.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic           clk,
  input  logic           resetn,
  cbus_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e               state_r;
  arb_state_e               state_nxt_s;
  logic [IDX_W-1:0]         sel_r;
  logic [IDX_W-1:0]         sel_nxt_s;
  logic [IDX_W-1:0]         prio_r;
  logic [IDX_W-1:0]         prio_nxt_s;
  logic [NUM_REQ-1:0]       valid_s;
  logic                     found_s;
  logic [IDX_W-1:0]         pick_s;
  logic                     sel_ok_s;
  cbus_req_t                oreq_s;
  cbus_resp_t [NUM_REQ-1:0] oresps_s;

  // Gather the per-requester valid bits for the picker.
  always_comb begin
    valid_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_s[i] = bus.ireqs[i].valid;
    end
  end

  cbus_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (valid_s),
    .prio  (prio_r),
    .found (found_s),
    .idx   (pick_s)
  );

  // A corrupted sel beyond the requester count behaves like IDLE.
  assign sel_ok_s = (int'(sel_r) < NUM_REQ);

  // Next-state and output routing; only the granted requester ever sees the response.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    prio_nxt_s  = prio_r;
    oreq_s      = '0;
    oresps_s    = '0;
    case (state_r)
      ARB_IDLE: begin
        if (found_s) begin
          sel_nxt_s   = pick_s;
          state_nxt_s = ARB_BUSY;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (!sel_ok_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          oreq_s          = bus.ireqs[sel_r];
          oresps_s[sel_r] = bus.oresp;
          if (bus.oresp.ready && bus.oresp.last) begin
            state_nxt_s = ARB_IDLE;
            prio_nxt_s  = IDX_W'((int'(sel_r) + 1) % NUM_REQ);
          end else begin
            state_nxt_s = ARB_BUSY;
          end
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // State, grant index and priority pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ARB_IDLE;
      sel_r   <= {IDX_W{1'b0}};
      prio_r  <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      prio_r  <= prio_nxt_s;
    end
  end

  assign bus.oreq   = oreq_s;
  assign bus.oresps = oresps_s;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios plus a random phase,
// all compared every cycle against an owner/priority model of the bus.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int NUM_REQ = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  cbus_arbiter #(.NUM_REQ(NUM_REQ)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus (-1 = nobody), next priority, beats done.
  int m_owner = -1;
  int m_prio  = 0;
  int m_beat  = 0;

  cbus_req_t  rq [NUM_REQ];
  cbus_resp_t rsp;
  int   p_start = 0;
  int   p_ready = 100;
  int   max_len = 0;
  int   dut_grants[$];
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_req(input int i, input logic [31:0] addr, input logic [3:0] len, input logic wr);
    rq[i].valid    = 1'b1;
    rq[i].is_write = wr;
    rq[i].size     = 3'd2;
    rq[i].addr     = addr;
    rq[i].strobe   = wr ? 4'hF : 4'h0;
    rq[i].data     = $urandom;
    rq[i].len      = len;
  endtask

  task automatic gen_stim();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rq[i].valid && p_start > 0 && int'($urandom_range(99, 0)) < p_start)
        start_req(i, {4'(i), 28'($urandom)}, 4'($urandom_range(max_len, 0)), 1'($urandom));
    end
    rsp = '0;
    rsp.data = $urandom;
    if (m_owner >= 0) begin
      if (int'($urandom_range(99, 0)) < p_ready) begin
        rsp.ready = 1'b1;
        rsp.last  = (m_beat == int'(rq[m_owner].len));
      end
    end else begin
      rsp.ready = 1'($urandom);
      rsp.last  = 1'($urandom);
    end
    bus.oresp = rsp;
    for (int i = 0; i < NUM_REQ; i++) bus.ireqs[i] = rq[i];
  endtask

  task automatic check_cycle();
    cbus_req_t  er;
    cbus_resp_t es;
    er = '0;
    if (resetn && m_owner >= 0) er = rq[m_owner];
    chk("oreq", 80'(bus.oreq), 80'(er));
    for (int j = 0; j < NUM_REQ; j++) begin
      es = '0;
      if (resetn && m_owner == j) es = rsp;
      chk($sformatf("oresps[%0d]", j), 80'(bus.oresps[j]), 80'(es));
    end
    if (bus.oreq.valid && !prev_valid) dut_grants.push_back(int'(bus.oreq.addr[31:28]));
    prev_valid = bus.oreq.valid;
  endtask

  // Ownership changes only at clock edges; a burst end frees the bus for one idle cycle.
  task automatic model_edge();
    if (!resetn) begin
      m_owner = -1;
      m_prio  = 0;
      m_beat  = 0;
    end else if (m_owner >= 0) begin
      if (rsp.ready && rsp.last) begin
        rq[m_owner].valid = 1'b0;
        m_prio  = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end else if (rsp.ready) begin
        m_beat++;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (m_owner < 0 && rq[(m_prio + k) % NUM_REQ].valid) begin
          m_owner = (m_prio + k) % NUM_REQ;
          m_beat  = 0;
        end
      end
    end
  endtask

  task automatic half_a();
    gen_stim();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) begin
      half_a();
      half_b();
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq[i] = '0;
    half_a();
    chk("reset oreq.valid", 80'(bus.oreq.valid), 80'(0));
    half_b();
    cycles(1);
    resetn = 1'b1;
    dut_grants.delete();
    prev_valid = 1'b0;
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 0, 1, 0, 1};
    for (int i = 0; i < NUM_REQ; i++) rq[i] = '0;
    rsp = '0;

    // Single read on requester 0.
    p_start = 0; p_ready = 100; max_len = 0;
    do_reset();
    start_req(0, 32'hBFC0_0000, 4'd0, 1'b0);
    half_a();
    chk("single: no grant same cycle", 80'(bus.oreq.valid), 80'(0));
    half_b();
    half_a();
    chk("single: valid", 80'(bus.oreq.valid), 80'(1));
    chk("single: addr", 80'(bus.oreq.addr), 80'(32'hBFC0_0000));
    chk("single: ready0", 80'(bus.oresps[0].ready), 80'(1));
    chk("single: last0", 80'(bus.oresps[0].last), 80'(1));
    chk("single: resp1", 80'(bus.oresps[1]), 80'(0));
    half_b();
    half_a();
    chk("single: idle after last", 80'(bus.oreq.valid), 80'(0));
    half_b();

    // Simultaneous requests and fairness: alternating grants from prio=0.
    do_reset();
    p_start = 100;
    cycles(13);
    p_start = 0;
    chk("fair: grant count", 80'(dut_grants.size() >= 6), 80'(1));
    for (int k = 0; k < 6; k++)
      chk($sformatf("fair: grant %0d", k), 80'(k < dut_grants.size() ? dut_grants[k] : -1), 80'(exp_order[k]));

    // Burst protection: len=3 on requester 1, requester 0 arrives at beat 2.
    do_reset();
    start_req(1, 32'h1000_0200, 4'd3, 1'b1);
    cycles(3);
    start_req(0, 32'h0000_0300, 4'd0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      half_a();
      chk("burst: still req1", 80'(bus.oreq.addr), 80'(32'h1000_0200));
      chk("burst: no ready0", 80'(bus.oresps[0].ready), 80'(0));
      half_b();
    end
    half_a();
    chk("burst: idle gap", 80'(bus.oreq.valid), 80'(0));
    half_b();
    half_a();
    chk("burst: req0 next", 80'(bus.oreq.addr), 80'(32'h0000_0300));
    half_b();

    // Reset during beat 2 of a len=7 write.
    do_reset();
    start_req(0, 32'h0000_0400, 4'd7, 1'b1);
    cycles(3);
    half_a();
    #2 resetn = 1'b0;
    #1;
    chk("rst: oreq.valid", 80'(bus.oreq.valid), 80'(0));
    chk("rst: oresps0", 80'(bus.oresps[0]), 80'(0));
    chk("rst: oresps1", 80'(bus.oresps[1]), 80'(0));
    for (int i = 0; i < NUM_REQ; i++) rq[i] = '0;
    half_b();
    cycles(1);
    resetn = 1'b1;
    start_req(1, 32'h1000_0500, 4'd0, 1'b0);
    cycles(1);
    half_a();
    chk("rst: req1 granted", 80'(bus.oreq.addr), 80'(32'h1000_0500));
    chk("rst: req1 valid", 80'(bus.oreq.valid), 80'(1));
    half_b();

    // Late arrival in the same cycle as the last beat.
    do_reset();
    start_req(0, 32'h0000_0100, 4'd0, 1'b0);
    cycles(1);
    start_req(1, 32'h1000_0040, 4'd0, 1'b0);
    half_a();
    chk("late: req0 last beat", 80'(bus.oresps[0].last), 80'(1));
    half_b();
    half_a();
    chk("late: not granted yet", 80'(bus.oreq.valid), 80'(0));
    half_b();
    half_a();
    chk("late: req1 addr", 80'(bus.oreq.addr), 80'(32'h1000_0040));
    half_b();

    // Random traffic against the model.
    do_reset();
    p_start = 30; max_len = 7; p_ready = 70;
    cycles(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
